i2s_audio_tx: RTL and testbench
===============================

# i2s_audio_tx

Serial audio output stage that sits directly downstream of the sound-effect synthesiser core. It takes that core's free-running 16-bit signed PCM word and transmits it as a mono-duplicated stereo I2S stream (Philips format) to an external DAC, generating BCLK and LRCK from the system clock. A per-frame gain ramp gives click-free fade-in after reset and a soft mute.

## Interface
- BCLK_HALF, 16: system-clock cycles per BCLK half-period; must be ≥ 2. Sample rate = f_clk / (64·BCLK_HALF), which is 48.83 kHz at 50 MHz.
- FADE_STEP, 1: gain change per frame while ramping; range 1..128.
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset; synchronous, active-high
- pcm_in  in  16  signed PCM sample from the synthesiser; no handshake
- mute  in  1  1 ramps the gain to 0, 0 ramps it to unity
- i2s_bclk  out  1  bit clock
- i2s_lrck  out  1  word select; 0 = left, 1 = right
- i2s_sdata  out  1  serial data, MSB first
- sample_strobe  out  1  one-cycle pulse on each clk where pcm_in is captured
- gain  out  8  current gain, 0..128; 128 = unity

## Operation
- **Divider**
  - div_cnt counts 0..BCLK_HALF−1. At the terminal count it wraps and i2s_bclk toggles.
  - A high→low toggle is a *fall event*.
- **Bit counter**
  - bit_cnt (5 bits) increments on each fall event and wraps 31→0.
  - Frame = 32 BCLKs, 16 per slot.
- **LRCK**
  - Registered on fall events: 0 when new bit_cnt is 0..15, 1 when it is 16..31.
  - It therefore changes one BCLK before the MSB, per Philips I2S.
- **SDATA**
  - On each fall event, i2s_sdata = out_word[15 − ((bit_cnt_new − 1) mod 16)].
  - bit_cnt 1..16 carry left MSB..LSB. bit_cnt 17..31 and 0 carry right MSB..LSB.
  - Both slots carry the same word.
- **Capture**
  - Occurs on the fall event where bit_cnt goes 0→1.
  - out_word ← sat-free (pcm_in × gain) >>> 7: a 16×8 signed product in 24 bits, arithmetic shift, truncating toward −∞.
  - gain = 128 gives exact passthrough.
  - The product uses the gain value *before* that cycle's update.
  - The new out_word drives sdata in that same cycle.
  - The previous word's right-slot LSB is emitted at bit_cnt 0, before out_word changes.
- **Gain update**
  - Happens in the same capture cycle, once per frame.
  - If mute: gain ← max(gain − FADE_STEP, 0). Else: gain ← min(gain + FADE_STEP, 128).
- **sample_strobe**
  - High exactly in the capture cycle.
- **Reset values**
  - i2s_bclk=0, i2s_lrck=0, i2s_sdata=0, sample_strobe=0, gain=0.
  - Internal registers: div_cnt=0, bit_cnt=0, out_word=0.

## Timing
- All outputs are registered. i2s_lrck and i2s_sdata change only in the clk cycle where i2s_bclk falls, and are stable through the whole high phase. The DAC samples on the BCLK rising edge.
- After rst deasserts at edge 0:
  - First BCLK rise: edge BCLK_HALF.
  - First fall event and first capture: edge 2·BCLK_HALF.
  - Captures then repeat every 64·BCLK_HALF clk.
- First capture uses gain 0 (word 0). Unity is reached at the (128/FADE_STEP + 1)th capture.
- pcm_in is sampled only at capture; values between captures are ignored.
- A mute change mid-frame takes effect at the next capture, never mid-word.
- rst asserted mid-frame: all state returns to reset values on the next clk edge. The frame restarts from bit_cnt 0 and the fade-in repeats.
- Gain at a limit: gain holds at 0 or 128. FADE_STEP not dividing 128 clamps the final step.

## Structure
- Shared audio package holds: FRAME_BITS=32, SLOT_BITS=16, GAIN_UNITY=128, GAIN_SHIFT=7, and the PCM sample type (signed 16).
- Sub-module i2s_clk_gen contains the divider and bit counter. It outputs i2s_bclk, fall_evt and bit_cnt.
- The top level holds capture, gain, the multiply and the serialiser.

## Test plan
- **Reset and startup** (BCLK_HALF=16): rst released, mute=0, pcm_in=16'h3000 → BCLK period 32 clk; first strobe at clk 32; strobe spacing 1024; gain sequence 1,2,…; the I2S decoder reads 0x0000 in frame 1 and 0x3000 in both slots from capture 129 on.
- **Format**: at unity, pcm_in=16'hD000 → decoder reads left=right=0xD000; the MSB appears on the second BCLK rise after each LRCK edge; no sdata/lrck transitions while bclk=1.
- **Gain arithmetic** (check out_word):
  - gain 64, pcm 0x3000 → 0x1800
  - gain 64, pcm 0xD000 → 0xE800
  - gain 1, pcm 0xFFFF → 0xFFFF
  - gain 1, pcm 0x007F → 0x0000
  - gain 128, pcm 0x8000 → 0x8000
- **Mute**: mute asserted at unity → gain falls 1 per frame, reaching 0 after 128 frames, then all sdata bits are 0. Deasserting mute ramps gain back to 128. A mid-frame toggle only affects the next capture.
- **Reset mid-operation**: rst pulsed at bit_cnt 20 → the next cycle has every output at its reset value and gain 0; the next strobe comes 2·BCLK_HALF after release.
- **Minimum divider**: BCLK_HALF=2, FADE_STEP=32 → frame 128 clk; gain 32,64,96,128 then holds; decoded data is correct.

Source files
------------

// File: rtl/i2s_audio_tx_pkg.sv
// Shared constants, sample type and gain arithmetic for the I2S audio output stage.
package i2s_audio_tx_pkg;

  localparam int FRAME_BITS = 32;
  localparam int SLOT_BITS  = 16;
  localparam int GAIN_UNITY = 128;
  localparam int GAIN_SHIFT = 7;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef logic signed [SLOT_BITS-1:0] pcm_t;
  typedef logic [7:0]                  gain_t;

  // 16x8 signed product in 24 bits; the arithmetic shift floors toward -inf.
  function automatic pcm_t apply_gain(input pcm_t sample, input gain_t g);
    logic signed [23:0] s_ext;
    logic signed [23:0] g_ext;
    logic signed [23:0] prod;
    logic signed [23:0] shifted;
    s_ext   = sample;
    g_ext   = {16'd0, g};
    prod    = s_ext * g_ext;
    shifted = prod >>> GAIN_SHIFT;
    return pcm_t'(shifted[SLOT_BITS-1:0]);
  endfunction

  function automatic gain_t next_gain(input gain_t g, input logic mute, input int step);
    logic [8:0] sum;
    sum = {1'b0, g} + 9'(step);
    if (mute) begin
      return (g > gain_t'(step)) ? g - gain_t'(step) : '0;
    end
    return (sum >= 9'(GAIN_UNITY)) ? gain_t'(GAIN_UNITY) : sum[7:0];
  endfunction

endpackage

// File: rtl/i2s_audio_tx_clk_gen.sv
// BCLK divider and frame bit counter; fall_evt marks the clk cycle in which BCLK goes low.
module i2s_clk_gen
  import i2s_audio_tx_pkg::*;
#(
  parameter int BCLK_HALF = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 i2s_bclk,
  output logic                 fall_evt,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             div_tc;

  assign div_tc   = (div_cnt == DIV_W'(BCLK_HALF - 1));
  assign fall_evt = div_tc & i2s_bclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      if (div_tc) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fall_evt) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// Mono-duplicated Philips I2S transmitter with a once-per-frame gain ramp for fade-in and soft mute.
module i2s_audio_tx
  import i2s_audio_tx_pkg::*;
#(
  parameter int BCLK_HALF = 16,
  parameter int FADE_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pcm_in,
  input  logic        mute,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata,
  output logic        sample_strobe,
  output logic [7:0]  gain
);

  logic                 fall_evt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_CNT_W-1:0] bit_new;
  logic                 capture;
  logic [3:0]           slot_pos;
  logic [3:0]           bit_idx;
  pcm_t                 out_word;
  pcm_t                 scaled;

  i2s_clk_gen #(
    .BCLK_HALF(BCLK_HALF)
  ) u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .i2s_bclk(i2s_bclk),
    .fall_evt(fall_evt),
    .bit_cnt (bit_cnt)
  );

  assign bit_new  = bit_cnt + 1'b1;
  assign capture  = fall_evt && (bit_cnt == '0);
  assign scaled   = apply_gain(pcm_t'(pcm_in), gain);
  // Slot position 0 is the MSB; bit_new 0 wraps to position 15, the right-slot LSB.
  assign slot_pos = bit_new[3:0] - 4'd1;
  assign bit_idx  = 4'd15 - slot_pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      i2s_lrck      <= 1'b0;
      i2s_sdata     <= 1'b0;
      sample_strobe <= 1'b0;
      gain          <= '0;
      out_word      <= '0;
    end else begin
      sample_strobe <= capture;
      if (fall_evt) begin
        i2s_lrck  <= bit_new[4];
        i2s_sdata <= capture ? scaled[SLOT_BITS-1] : out_word[bit_idx];
      end
      if (capture) begin
        out_word <= scaled;
        gain     <= next_gain(gain, mute, FADE_STEP);
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: three instances (BCLK_HALF 16/2/2, FADE_STEP 1/1/32), I2S decoder and scoreboard.
module tb_i2s_audio_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [3];
  logic [15:0] pcm    [3];
  logic        mute   [3];
  logic        bclk   [3];
  logic        lrck   [3];
  logic        sdata  [3];
  logic        strobe [3];
  logic [7:0]  gain   [3];

  int n_checks = 0;
  int n_errors = 0;
  int act = 0;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      i2s_audio_tx #(
        .BCLK_HALF(g == 0 ? 16 : 2),
        .FADE_STEP(g == 2 ? 32 : 1)
      ) u_dut (
        .clk          (clk),
        .rst          (rst[g]),
        .pcm_in       (pcm[g]),
        .mute         (mute[g]),
        .i2s_bclk     (bclk[g]),
        .i2s_lrck     (lrck[g]),
        .i2s_sdata    (sdata[g]),
        .sample_strobe(strobe[g]),
        .gain         (gain[g])
      );
    end
  endgenerate

  // Reference model
  function automatic logic [15:0] model_scale(input logic [15:0] p, input int g);
    int prod;
    int q;
    prod = int'($signed(p)) * g;
    q = prod / 128;
    if (prod < 0 && (prod % 128) != 0) q = q - 1;
    return q[15:0];
  endfunction

  function automatic int model_gain(input int g, input logic m, input int step);
    int n;
    n = m ? g - step : g + step;
    if (n < 0) n = 0;
    if (n > 128) n = 128;
    return n;
  endfunction

  // Scoreboard: expected slot words pushed at each capture, popped as the decoder completes words
  typedef struct packed {
    logic        slot;
    logic [15:0] word;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] pcm_d;
  logic        mute_d;
  int          gm;
  logic        m_pb, m_plr;
  logic [15:0] shreg;
  logic [15:0] last_left, last_right;
  int          words_seen = 0;

  always @(posedge clk) begin
    pcm_d  <= pcm[act];
    mute_d <= mute[act];
  end

  always @(negedge clk) begin
    exp_t        it;
    logic [15:0] e;
    logic [15:0] w;
    if (rst[act]) begin
      sb.delete();
      gm    = 0;
      m_pb  = 1'b0;
      m_plr = 1'b0;
      shreg = '0;
    end else begin
      if (strobe[act]) begin
        e = model_scale(pcm_d, gm);
        it.slot = 1'b0; it.word = e; sb.push_back(it);
        it.slot = 1'b1; it.word = e; sb.push_back(it);
        gm = model_gain(gm, mute_d, act == 2 ? 32 : 1);
        n_checks++;
        if (gain[act] !== 8'(gm)) begin
          n_errors++;
          $display("FAIL gain_track inst %0d: got %0d expected %0d", act, gain[act], gm);
        end
      end
      if (bclk[act] && !m_pb) begin
        if (lrck[act] !== m_plr) begin
          w = {shreg[14:0], sdata[act]};
          words_seen++;
          if (m_plr) last_right = w; else last_left = w;
          n_checks++;
          if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL decode_unexpected inst %0d: got word %h slot %0d with nothing expected", act, w, m_plr);
          end else begin
            it = sb.pop_front();
            if (it.slot !== m_plr || it.word !== w) begin
              n_errors++;
              $display("FAIL decode_word inst %0d: got %h slot %0d expected %h slot %0d", act, w, m_plr, it.word, it.slot);
            end
          end
        end
        shreg = {shreg[14:0], sdata[act]};
        m_plr = lrck[act];
      end
      m_pb = bclk[act];
    end
  end

  task automatic wait_strobe(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!strobe[act] && cyc < limit);
    if (!strobe[act]) begin
      n_checks++;
      n_errors++;
      $display("FAIL strobe_timeout inst %0d: no strobe within %0d clk", act, limit);
    end
  endtask

  // Edge 0 is the posedge that samples rst high; rst drops at the following negedge.
  task automatic start(input int i);
    act = i;
    rst[i] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst[i] = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; pcm[i] = 16'h0000; mute[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({bclk[i], lrck[i], sdata[i], strobe[i]} !== 4'b0000) begin
        n_errors++;
        $display("FAIL reset_outputs inst %0d: got bclk/lrck/sdata/strobe %b expected 0000", i, {bclk[i], lrck[i], sdata[i], strobe[i]});
      end
      n_checks++;
      if (gain[i] !== 8'd0) begin
        n_errors++;
        $display("FAIL reset_gain inst %0d: got %0d expected 0", i, gain[i]);
      end
    end
  endtask

  task automatic test_startup();
    int   rise0, rise1, st0, st1, st2, n_st;
    logic pb;
    rise0 = -1; rise1 = -1; st0 = -1; st1 = -1; st2 = -1; n_st = 0; pb = 1'b0;
    pcm[0] = 16'h3000; mute[0] = 1'b0;
    start(0);
    for (int c = 1; c <= 2200; c++) begin
      @(negedge clk);
      if (bclk[0] && !pb) begin
        if (rise0 < 0) rise0 = c;
        else if (rise1 < 0) rise1 = c;
      end
      pb = bclk[0];
      if (strobe[0]) begin
        n_st++;
        if (n_st == 1) st0 = c; else if (n_st == 2) st1 = c; else if (n_st == 3) st2 = c;
      end
    end
    n_checks++;
    if (rise0 !== 16) begin n_errors++; $display("FAIL first_bclk_rise: got clk %0d expected 16", rise0); end
    n_checks++;
    if (rise1 - rise0 !== 32) begin n_errors++; $display("FAIL bclk_period: got %0d expected 32", rise1 - rise0); end
    n_checks++;
    if (st0 !== 32) begin n_errors++; $display("FAIL first_strobe: got clk %0d expected 32", st0); end
    n_checks++;
    if (st1 - st0 !== 1024 || st2 - st1 !== 1024) begin
      n_errors++; $display("FAIL strobe_spacing: got %0d,%0d expected 1024", st1 - st0, st2 - st1);
    end
    n_checks++;
    if (n_st !== 3) begin n_errors++; $display("FAIL strobe_count: got %0d expected 3", n_st); end
    n_checks++;
    if (gain[0] !== 8'd3) begin n_errors++; $display("FAIL startup_gain: got %0d expected 3", gain[0]); end
    n_checks++;
    if (last_left !== 16'h0060 || last_right !== 16'h0060) begin
      n_errors++; $display("FAIL startup_frame2: got L=%h R=%h expected 0060", last_left, last_right);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    int cyc;
    c = 0;
    while (g_dut[0].u_dut.u_clk_gen.bit_cnt !== 5'd20 && c < 2100) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (g_dut[0].u_dut.u_clk_gen.bit_cnt !== 5'd20 || lrck[0] !== 1'b1) begin
      n_errors++; $display("FAIL reach_bit20: got bit_cnt %0d lrck %b expected 20 1", g_dut[0].u_dut.u_clk_gen.bit_cnt, lrck[0]);
    end
    rst[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bclk[0], lrck[0], sdata[0], strobe[0]} !== 4'b0000 || gain[0] !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_mid_outputs: got bclk/lrck/sdata/strobe %b gain %0d expected 0000 0", {bclk[0], lrck[0], sdata[0], strobe[0]}, gain[0]);
    end
    n_checks++;
    if (g_dut[0].u_dut.u_clk_gen.bit_cnt !== 5'd0 || g_dut[0].u_dut.out_word !== 16'h0000) begin
      n_errors++; $display("FAIL reset_mid_internal: got bit_cnt %0d out_word %h expected 0 0000", g_dut[0].u_dut.u_clk_gen.bit_cnt, g_dut[0].u_dut.out_word);
    end
    rst[0] = 1'b0;
    wait_strobe(200, cyc);
    n_checks++;
    if (cyc !== 32) begin n_errors++; $display("FAIL reset_mid_strobe: got clk %0d expected 32", cyc); end
    n_checks++;
    if (gain[0] !== 8'd1) begin n_errors++; $display("FAIL reset_mid_fade: got %0d expected 1", gain[0]); end
    rst[0] = 1'b1;
  endtask

  task automatic test_fade_in();
    int cyc;
    int exp_g;
    pcm[1] = 16'h3000; mute[1] = 1'b0;
    start(1);
    for (int k = 1; k <= 130; k++) begin
      wait_strobe(200, cyc);
      if (k == 1) begin
        n_checks++;
        if (cyc !== 4) begin n_errors++; $display("FAIL fade_first_strobe: got clk %0d expected 4", cyc); end
      end
      exp_g = (k < 128) ? k : 128;
      n_checks++;
      if (gain[1] !== 8'(exp_g)) begin n_errors++; $display("FAIL fade_gain k=%0d: got %0d expected %0d", k, gain[1], exp_g); end
      if (k == 2) begin
        n_checks++;
        if (g_dut[1].u_dut.out_word !== 16'hFFFF) begin n_errors++; $display("FAIL arith_g1_ffff: got %h expected ffff", g_dut[1].u_dut.out_word); end
      end
      if (k == 65) begin
        n_checks++;
        if (g_dut[1].u_dut.out_word !== 16'h1800) begin n_errors++; $display("FAIL arith_g64_3000: got %h expected 1800", g_dut[1].u_dut.out_word); end
      end
      pcm[1] = (k == 1) ? 16'hFFFF : 16'h3000;
    end
    n_checks++;
    if (g_dut[1].u_dut.out_word !== 16'h3000) begin n_errors++; $display("FAIL unity_passthrough: got %h expected 3000", g_dut[1].u_dut.out_word); end
  endtask

  task automatic test_format();
    int   cyc, rises_after, viol, msb_bad, msb_seen, w0;
    logic pb, plr, psd, plr_r;
    viol = 0; msb_bad = 0; msb_seen = 0;
    pcm[1] = 16'hD000;
    wait_strobe(200, cyc);
    w0 = words_seen;
    pb = bclk[1]; plr = lrck[1]; psd = sdata[1]; plr_r = lrck[1]; rises_after = 1;
    for (int c = 0; c < 3 * 128; c++) begin
      @(negedge clk);
      if (bclk[1] && pb && (lrck[1] !== plr || sdata[1] !== psd)) viol++;
      if (bclk[1] && !pb) begin
        if (lrck[1] !== plr_r) rises_after = 1; else rises_after++;
        if (rises_after == 2) begin
          msb_seen++;
          if (sdata[1] !== 1'b1) msb_bad++;
        end
        plr_r = lrck[1];
      end
      pb = bclk[1]; plr = lrck[1]; psd = sdata[1];
    end
    n_checks++;
    if (viol !== 0) begin n_errors++; $display("FAIL stable_high_phase: got %0d changes expected 0", viol); end
    n_checks++;
    if (msb_seen !== 6 || msb_bad !== 0) begin
      n_errors++; $display("FAIL msb_position: got %0d slots %0d bad expected 6 slots 0 bad", msb_seen, msb_bad);
    end
    n_checks++;
    if (words_seen - w0 < 5 || last_left !== 16'hD000 || last_right !== 16'hD000) begin
      n_errors++; $display("FAIL format_words: got %0d words L=%h R=%h expected >=5 d000", words_seen - w0, last_left, last_right);
    end
    pcm[1] = 16'h8000;
    wait_strobe(200, cyc);
    n_checks++;
    if (g_dut[1].u_dut.out_word !== 16'h8000) begin n_errors++; $display("FAIL arith_g128_8000: got %h expected 8000", g_dut[1].u_dut.out_word); end
  endtask

  task automatic test_mute();
    int cyc, exp_g, ones;
    repeat (40) @(negedge clk);
    mute[1] = 1'b1;
    repeat (20) @(negedge clk);
    mute[1] = 1'b0;
    wait_strobe(200, cyc);
    n_checks++;
    if (gain[1] !== 8'd128) begin n_errors++; $display("FAIL mute_glitch: got %0d expected 128", gain[1]); end
    repeat (30) @(negedge clk);
    mute[1] = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      wait_strobe(200, cyc);
      exp_g = (128 - k > 0) ? 128 - k : 0;
      n_checks++;
      if (gain[1] !== 8'(exp_g)) begin n_errors++; $display("FAIL mute_gain k=%0d: got %0d expected %0d", k, gain[1], exp_g); end
      if (k == 65) begin
        n_checks++;
        if (g_dut[1].u_dut.out_word !== 16'hE800) begin n_errors++; $display("FAIL arith_g64_d000: got %h expected e800", g_dut[1].u_dut.out_word); end
      end
      if (k == 128) begin
        n_checks++;
        if (g_dut[1].u_dut.out_word !== 16'h0000) begin n_errors++; $display("FAIL arith_g1_007f: got %h expected 0000", g_dut[1].u_dut.out_word); end
      end
      pcm[1] = (k == 64) ? 16'hD000 : (k == 127) ? 16'h007F : (k >= 128) ? 16'h7FFF : 16'h3000;
    end
    ones = 0;
    for (int c = 0; c < 128; c++) begin
      @(negedge clk);
      if (sdata[1] !== 1'b0) ones++;
    end
    n_checks++;
    if (ones !== 0) begin n_errors++; $display("FAIL muted_sdata: got %0d high cycles expected 0", ones); end
    repeat (30) @(negedge clk);
    mute[1] = 1'b0;
    pcm[1] = 16'h3000;
    for (int k = 1; k <= 129; k++) begin
      wait_strobe(200, cyc);
      exp_g = (k < 128) ? k : 128;
      n_checks++;
      if (gain[1] !== 8'(exp_g)) begin n_errors++; $display("FAIL unmute_gain k=%0d: got %0d expected %0d", k, gain[1], exp_g); end
    end
    rst[1] = 1'b1;
  endtask

  task automatic test_min_divider();
    int   cyc, rise0, rise1;
    logic pb;
    int   exp_g [6] = '{32, 64, 96, 128, 128, 128};
    pcm[2] = 16'h4000; mute[2] = 1'b0;
    start(2);
    for (int k = 0; k < 6; k++) begin
      wait_strobe(300, cyc);
      n_checks++;
      if (cyc !== (k == 0 ? 4 : 128)) begin n_errors++; $display("FAIL min_strobe_spacing k=%0d: got %0d expected %0d", k, cyc, k == 0 ? 4 : 128); end
      n_checks++;
      if (gain[2] !== 8'(exp_g[k])) begin n_errors++; $display("FAIL min_gain k=%0d: got %0d expected %0d", k, gain[2], exp_g[k]); end
    end
    rise0 = -1; rise1 = -1; pb = bclk[2];
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      if (bclk[2] && !pb) begin
        if (rise0 < 0) rise0 = c; else if (rise1 < 0) rise1 = c;
      end
      pb = bclk[2];
    end
    n_checks++;
    if (rise1 - rise0 !== 4) begin n_errors++; $display("FAIL min_bclk_period: got %0d expected 4", rise1 - rise0); end
    n_checks++;
    if (last_left !== 16'h4000 || last_right !== 16'h4000) begin
      n_errors++; $display("FAIL min_decode: got L=%h R=%h expected 4000", last_left, last_right);
    end
    rst[2] = 1'b1;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_reset_mid();
    test_fade_in();
    test_format();
    test_mute();
    test_min_divider();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
